// File: rtl/pulse_pkg.sv
// Shared types and width helpers for the pulse meter/checker.
// Also holds the state encoding used by the top-level FSM.
package pulse_pkg;

  function automatic int f_Data2W(input int n);
    int w;
    w = 1;
    while (n >= (1 << w)) w++;
    return w;
  endfunction

  function automatic int f_MaxNum(input int w);
    return (1 << w) - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for the pulse line plus an edge register.
// Produces the settled level and one-cycle rise/fall strobes.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic s2,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/pulse_hl_meter_chk.sv
// Measures high/low time of a periodic pulse, checks each period
// against expected times, and tracks lock and stuck-level timeout.
module pulse_hl_meter_chk
  import pulse_pkg::*;
#(
  parameter int CLK_PERIOD_TIME = 50,
  parameter int HIGH_TIME       = 500,
  parameter int TOTAL_TIME      = 1000,
  parameter int TOL_CLK         = 2,
  parameter int LOCK_NUM        = 4,
  parameter int TIMEOUT_TIME    = 5000,
  localparam int EXP_H  = HIGH_TIME / CLK_PERIOD_TIME,
  localparam int EXP_T  = TOTAL_TIME / CLK_PERIOD_TIME,
  localparam int TO_CLK = TIMEOUT_TIME / CLK_PERIOD_TIME,
  localparam int CNT_W  = f_Data2W(TO_CLK)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             PULSE_I,
  output logic [CNT_W-1:0] HIGH_CNT_O,
  output logic [CNT_W-1:0] LOW_CNT_O,
  output logic             VALID_O,
  output logic             ERR_O,
  output logic             LOCK_O,
  output logic             TIMEOUT_O
);

  localparam int GW = f_Data2W(LOCK_NUM);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   ext_t;
  typedef logic [GW-1:0]    good_t;

  localparam cnt_t  CNT_MAX = cnt_t'(f_MaxNum(CNT_W));
  localparam cnt_t  TO_PRE  = cnt_t'(TO_CLK - 1);
  localparam ext_t  EXP_HX  = ext_t'(EXP_H);
  localparam ext_t  EXP_TX  = ext_t'(EXP_T);
  localparam ext_t  TOL_X   = ext_t'(TOL_CLK);
  localparam good_t GOOD_MX = good_t'(LOCK_NUM);

  logic   s2;
  logic   rise;
  logic   fall;
  state_t state;
  cnt_t   lvl_cnt;
  cnt_t   h_cnt;
  good_t  good_cnt;
  good_t  good_nxt;
  logic [1:0] warm;
  logic   to_hit;
  ext_t   h_x;
  ext_t   tot_x;
  ext_t   dh;
  ext_t   dt;
  logic   err_now;

  pulse_sync_edge u_sync (
    .clk  (CLK_I),
    .rst  (RST_I),
    .pulse(PULSE_I),
    .s2   (s2),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      lvl_cnt <= '0;
    end else if (rise || fall) begin
      lvl_cnt <= cnt_t'(1);
    end else if (lvl_cnt != CNT_MAX) begin
      lvl_cnt <= lvl_cnt + 1'b1;
    end
  end

  // An edge reloads the counter, so a rise always beats a timeout.
  assign to_hit = !(rise || fall) && (lvl_cnt == TO_PRE);

  always_comb begin
    h_x   = {1'b0, h_cnt};
    tot_x = h_x + {1'b0, lvl_cnt};
    dh    = (h_x > EXP_HX) ? h_x - EXP_HX : EXP_HX - h_x;
    dt    = (tot_x > EXP_TX) ? tot_x - EXP_TX : EXP_TX - tot_x;
    err_now  = (dh > TOL_X) || (dt > TOL_X);
    good_nxt = (good_cnt == GOOD_MX) ? good_cnt : good_cnt + 1'b1;
  end

  // IDLE trusts s2 only once the synchronizer holds a real sample.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      warm       <= '0;
      h_cnt      <= '0;
      good_cnt   <= '0;
      HIGH_CNT_O <= '0;
      LOW_CNT_O  <= '0;
      VALID_O    <= 1'b0;
      ERR_O      <= 1'b0;
      LOCK_O     <= 1'b0;
      TIMEOUT_O  <= 1'b0;
    end else begin
      warm    <= {warm[0], 1'b1};
      VALID_O <= 1'b0;
      if (to_hit) begin
        TIMEOUT_O <= 1'b1;
        LOCK_O    <= 1'b0;
        good_cnt  <= '0;
        state     <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (warm[1] && !s2) state <= ARM;
          ARM: begin
            if (rise) begin
              TIMEOUT_O <= 1'b0;
              state     <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              h_cnt <= lvl_cnt;
              state <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              HIGH_CNT_O <= h_cnt;
              LOW_CNT_O  <= lvl_cnt;
              VALID_O    <= 1'b1;
              ERR_O      <= err_now;
              if (err_now) begin
                good_cnt <= '0;
                LOCK_O   <= 1'b0;
              end else begin
                good_cnt <= good_nxt;
                LOCK_O   <= (good_nxt == GOOD_MX);
              end
              state <= HIGH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_hl_meter_chk.sv
// Scoreboard bench for pulse_hl_meter_chk with default parameters.
// Expected measurements are queued as periods are driven.
`timescale 1ns/1ps
module tb_pulse_hl_meter_chk;

  typedef struct {
    int   h;
    int   l;
    logic err;
    logic lock;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic [6:0] high_cnt;
  logic [6:0] low_cnt;
  logic       valid;
  logic       err;
  logic       lock;
  logic       timeout;

  exp_t q[$];
  int   total;
  int   bad;
  int   m_good;
  logic prev_valid;

  pulse_hl_meter_chk dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .PULSE_I   (pulse),
    .HIGH_CNT_O(high_cnt),
    .LOW_CNT_O (low_cnt),
    .VALID_O   (valid),
    .ERR_O     (err),
    .LOCK_O    (lock),
    .TIMEOUT_O (timeout)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic push_exp(input int h, input int l);
    exp_t e;
    int   dh;
    int   dt;
    dh = (h > 10) ? h - 10 : 10 - h;
    dt = (h + l > 20) ? h + l - 20 : 20 - (h + l);
    e.h   = h;
    e.l   = l;
    e.err = (dh > 2) || (dt > 2);
    if (e.err) m_good = 0;
    else if (m_good < 4) m_good++;
    e.lock = (m_good == 4);
    q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (valid) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_width got=2+ cycles exp=1");
      end
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid h=%0d l=%0d", high_cnt, low_cnt);
      end else begin
        e = q.pop_front();
        total++;
        if (high_cnt !== 7'(e.h)) begin
          bad++;
          $display("FAIL high_cnt got=%0d exp=%0d", high_cnt, e.h);
        end
        total++;
        if (low_cnt !== 7'(e.l)) begin
          bad++;
          $display("FAIL low_cnt got=%0d exp=%0d", low_cnt, e.l);
        end
        total++;
        if (err !== e.err) begin
          bad++;
          $display("FAIL err got=%b exp=%b", err, e.err);
        end
        total++;
        if (lock !== e.lock) begin
          bad++;
          $display("FAIL lock got=%b exp=%b", lock, e.lock);
        end
      end
    end
    prev_valid = valid;
  endtask

  task automatic drive(input logic v, input int n);
    pulse = v;
    repeat (n) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic period(input int h, input int l);
    push_exp(h, l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({high_cnt, low_cnt, valid, err, lock, timeout} !== '0) begin
      bad++;
      $display("FAIL %s outs got=%h/%h v%b e%b l%b t%b exp=all0",
               tag, high_cnt, low_cnt, valid, err, lock, timeout);
    end
  endtask

  task automatic check_bit(input string tag, input logic got,
                           input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s pending got=%0d exp=0", tag, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pulse = 1'b0;
    prev_valid = 1'b0;
    m_good = 0;
    #5;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 5);
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 4; i++) period(10, 10);
  endtask

  task automatic test_out_of_tol();
    period(13, 10);
    for (int i = 0; i < 4; i++) period(10, 10);
  endtask

  task automatic test_in_tol();
    period(12, 9);
  endtask

  task automatic test_stuck_low();
    drive(1'b1, 10);
    drive(1'b0, 95);
    check_bit("to_before", timeout, 1'b0);
    check_bit("lock_before_to", lock, 1'b1);
    drive(1'b0, 15);
    check_bit("to_set", timeout, 1'b1);
    check_bit("lock_cleared_to", lock, 1'b0);
    m_good = 0;
    drive(1'b0, 40);
    check_empty("stuck_low");
    push_exp(10, 10);
    drive(1'b1, 4);
    check_bit("to_cleared", timeout, 1'b0);
    drive(1'b1, 6);
    drive(1'b0, 10);
    drive(1'b1, 5);
    check_empty("to_recover");
  endtask

  task automatic test_high_at_reset();
    rst = 1'b1;
    q.delete();
    m_good = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_valid = 1'b0;
    drive(1'b1, 20);
    drive(1'b0, 10);
    for (int i = 0; i < 4; i++) period(10, 10);
    drive(1'b1, 5);
    check_empty("high_at_reset");
  endtask

  task automatic test_async_reset();
    check_bit("lock_pre_async", lock, 1'b1);
    #10;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    q.delete();
    m_good = 0;
    @(posedge clk);
    #1;
    pulse = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_valid = 1'b0;
    drive(1'b0, 5);
    for (int i = 0; i < 4; i++) period(10, 10);
    drive(1'b1, 5);
    check_empty("relock");
    check_bit("relock_lock", lock, 1'b1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_nominal();
    test_out_of_tol();
    test_in_tol();
    test_stuck_low();
    test_high_at_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
